// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundle between the MEM stage and its environment: the EX/MEM request side
// and the external single-port SRAM pins.
interface mem_stage_sram_ctrl_if #(
  parameter int REGISTER_LEN  = 32,
  parameter int SRAM_ADDR_LEN = 18
);
  logic                     mem_r_en;
  logic                     mem_w_en;
  logic [REGISTER_LEN-1:0]  alu_res;
  logic [REGISTER_LEN-1:0]  val_Rm;
  logic [REGISTER_LEN-1:0]  mem_rdata;
  logic                     freeze;
  logic                     ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [REGISTER_LEN-1:0]  sram_wdata;
  logic [REGISTER_LEN-1:0]  sram_rdata;
  logic                     sram_we_n;
  logic                     sram_oe_n;

  // master: pipeline plus SRAM device; slave: the controller
  modport master (
    output mem_r_en, mem_w_en, alu_res, val_Rm, sram_rdata,
    input  mem_rdata, freeze, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );
  modport slave (
    input  mem_r_en, mem_w_en, alu_res, val_Rm, sram_rdata,
    output mem_rdata, freeze, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage SRAM controller: one multi-cycle load/store at a time, stalling
// the pipeline via freeze until the DONE cycle.
module mem_stage_sram_ctrl #(
  parameter int REGISTER_LEN  = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int MEM_BASE      = 1024,
  parameter int WAIT_CYCLES   = 4
) (
  input logic clk,
  input logic rst,
  mem_stage_sram_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     wr_q, wr_d;
  logic [REGISTER_LEN-1:0]  rdata_q, rdata_d;
  logic [SRAM_ADDR_LEN-1:0] addr_q, addr_d;
  logic [REGISTER_LEN-1:0]  wdata_q, wdata_d;
  logic                     we_n_q, we_n_d;
  logic                     oe_n_q, oe_n_d;

  logic [REGISTER_LEN-1:0]  offset;
  logic                     req;
  logic                     unused_ok;

  // Byte offset from the SRAM window; bits outside the word address wrap silently
  assign offset    = bus.alu_res - REGISTER_LEN'(MEM_BASE);
  assign unused_ok = ^{offset[REGISTER_LEN-1:SRAM_ADDR_LEN+2], offset[1:0]};
  assign req       = bus.mem_r_en | bus.mem_w_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = we_n_q;
    oe_n_d  = oe_n_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = offset[SRAM_ADDR_LEN+1:2];
        wr_d    = bus.mem_w_en;
        if (bus.mem_w_en) wdata_d = bus.val_Rm;
        cnt_d   = '0;
        // write wins when both enables are set
        we_n_d  = ~bus.mem_w_en;
        oe_n_d  = bus.mem_w_en;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          if (!wr_q) rdata_d = bus.sram_rdata;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  // Combinational so the stall reaches upstream registers in the request cycle
  assign bus.freeze     = rst & req & (state_q != DONE);
  assign bus.ready      = (state_q == DONE);
  assign bus.mem_rdata  = rdata_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: vector table of loads/stores against a
// behavioural SRAM, load results checked through a scoreboard queue.
module tb_mem_stage_sram_ctrl;
  localparam int RL = 32, AL = 18, BASE = 1024, WC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.REGISTER_LEN(RL), .SRAM_ADDR_LEN(AL)) bus();
  mem_stage_sram_ctrl #(.REGISTER_LEN(RL), .SRAM_ADDR_LEN(AL), .MEM_BASE(BASE),
                        .WAIT_CYCLES(WC)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural SRAM, 64 words decoded from the low address bits
  logic [31:0] sram_mem [0:63];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 64; i++) sram_mem[i] <= 32'hC0DE0000 + 32'(i);
    else if (!bus.sram_we_n) sram_mem[bus.sram_addr[5:0]] <= bus.sram_wdata;
  end
  assign bus.sram_rdata = !bus.sram_oe_n ? sram_mem[bus.sram_addr[5:0]] : 32'h0BADF00D;

  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q [$];
  logic [31:0] exp_hold;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    bit          gap;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AL-1:0] word_of(input logic [31:0] a);
    logic [31:0] t;
    t = (a - 32'(BASE)) >> 2;
    return t[AL-1:0];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.alu_res  = a;
    bus.val_Rm   = d;
  endtask

  // Drives one request starting in an IDLE cycle and follows it to DONE
  task automatic access(input vec_t v);
    logic [AL-1:0] ea;
    int cyc, frz, wel, oel, both, bad;
    bit done;
    ea = word_of(v.addr);
    cyc = 0; frz = 0; wel = 0; oel = 0; both = 0; bad = 0; done = 0;
    drive(v.r, v.w, v.addr, v.data);
    if (v.w) ref_mem[ea[5:0]] = v.data;
    else if (v.r) exp_hold = ref_mem[ea[5:0]];
    exp_q.push_back(exp_hold);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.freeze) frz++;
      if (!bus.sram_we_n) wel++;
      if (!bus.sram_oe_n) oel++;
      if (!bus.sram_we_n && !bus.sram_oe_n) both++;
      if ((!bus.sram_we_n || !bus.sram_oe_n) &&
          (bus.sram_addr !== ea || (v.w && bus.sram_wdata !== v.data))) bad++;
      if (bus.ready) begin
        done = 1;
        chk("rdata_done", bus.mem_rdata, exp_q.pop_front());
      end
    end
    chk("ready_seen", 32'(done), 32'd1);
    chk("access_cycles", 32'(cyc), 32'(WC + 2));
    chk("freeze_cycles", 32'(frz), 32'(WC + 1));
    chk("we_cycles", 32'(wel), v.w ? 32'(WC) : 32'd0);
    chk("oe_cycles", 32'(oel), v.w ? 32'd0 : 32'(WC));
    chk("strobe_overlap", 32'(both), 32'd0);
    chk("addr_wdata_hold", 32'(bad), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_freeze", 32'(bus.freeze), 32'd0);
      chk("idle_strobes", 32'({bus.sram_we_n, bus.sram_oe_n}), 32'd3);
      chk("idle_ready", 32'(bus.ready), 32'd0);
      chk("idle_rdata_hold", bus.mem_rdata, exp_hold);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b1};
    vt[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b1};
    vt[2] = '{1'b1, 1'b1, 32'd1036, 32'h00001234, 1'b1};
    vt[3] = '{1'b1, 1'b0, 32'd1036, 32'h0,        1'b1};
    vt[4] = '{1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b1};
    vt[6] = '{1'b1, 1'b0, 32'd1033, 32'h0,        1'b1};
    vt[7] = '{1'b0, 1'b1, 32'd1020, 32'h600DCAFE, 1'b0};
    vt[8] = '{1'b1, 1'b0, 32'd1020, 32'h0,        1'b1};
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE0000 + 32'(i);
    exp_hold = 32'h0;

    // Reset held with a pending load
    init_mem = 1'b1;
    drive(1'b1, 1'b0, 32'd1032, 32'h0);
    repeat (2) @(posedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    chk("rst_freeze", 32'(bus.freeze), 32'd0);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_addr", 32'(bus.sram_addr), 32'h0);
    chk("rst_wdata", bus.sram_wdata, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) begin
      access(vt[i]);
      if (vt[i].gap) idle(2);
    end
    chk("wrap_addr", 32'(word_of(32'd1020)), 32'h3FFFF);

    // Reset while a load is in its third ACCESS cycle
    drive(1'b1, 1'b0, 32'd1024, 32'h0);
    repeat (4) @(negedge clk);
    chk("pre_rst_oe_n", 32'(bus.sram_oe_n), 32'd0);
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mid_rst_strobes", 32'({bus.sram_we_n, bus.sram_oe_n}), 32'd3);
    chk("mid_rst_freeze", 32'(bus.freeze), 32'd0);
    chk("mid_rst_rdata", bus.mem_rdata, 32'h0);
    exp_hold = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    access('{1'b1, 1'b0, 32'd1024, 32'h0, 1'b1});
    idle(1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory stage of the pipelined ARM core, directly downstream of the EX/MEM pipeline register. It consumes the registered ALU result (address), Rm value (store data) and memory read/write enables. It runs a multi-cycle access on an external single-port SRAM and stalls the whole pipeline through `freeze` until the access completes. The loaded word goes to the MEM/WB register.

Parameters:
REGISTER_LEN, 32, data and address word width
SRAM_ADDR_LEN, 18, SRAM word-address width
MEM_BASE, 1024, byte address mapped to SRAM word 0
WAIT_CYCLES, 4, SRAM access cycles (>=1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
mem_r_en  in  1  load request from EX/MEM register
mem_w_en  in  1  store request from EX/MEM register
alu_res  in  REGISTER_LEN  byte address
val_Rm  in  REGISTER_LEN  store data
mem_rdata  out  REGISTER_LEN  loaded word, registered
freeze  out  1  stall request to all pipeline registers and PC
ready  out  1  access complete this cycle
sram_addr  out  SRAM_ADDR_LEN  SRAM word address, registered
sram_wdata  out  REGISTER_LEN  SRAM write data, registered
sram_rdata  in  REGISTER_LEN  SRAM read data
sram_we_n  out  1  SRAM write enable, active-low, registered
sram_oe_n  out  1  SRAM output enable, active-low, registered

Behaviour:
- Reset (rst=0, asynchronous) forces state IDLE, cnt=0, mem_rdata=0, sram_addr=0, sram_wdata=0, sram_we_n=1, sram_oe_n=1, ready=0. `freeze` is forced 0 while rst=0.
- Address: sram_addr = ((alu_res - MEM_BASE) >> 2)[SRAM_ADDR_LEN-1:0]. Subtraction is modulo 2^REGISTER_LEN. Low two address bits are ignored. Out-of-range addresses wrap and are not flagged.
- FSM states IDLE, ACCESS, DONE.
- IDLE:
  - If mem_w_en=1 or mem_r_en=1: latch sram_addr. For a store, also latch sram_wdata=val_Rm and set op=write. Go to ACCESS with cnt=0.
  - Drive sram_we_n=0 for a write, or sram_oe_n=0 for a read, from the first ACCESS cycle.
  - If both enables are 1, the write wins: no read is performed and mem_rdata is unchanged.
- ACCESS:
  - Hold addr, wdata and strobes stable. Increment cnt each cycle.
  - When cnt==WAIT_CYCLES-1:
    - Read: capture sram_rdata into mem_rdata.
    - Deassert both strobes (registered, so they are 1 in DONE).
    - Go to DONE.
- DONE: ready=1. Next state is IDLE unconditionally. Request inputs are ignored here, since they still belong to the completing instruction.
- freeze = rst & (mem_r_en | mem_w_en) & ~(state==DONE). It is combinational so the stall is visible in the request cycle.
- Latency:
  - An access occupies WAIT_CYCLES+2 cycles: 1 IDLE + WAIT_CYCLES ACCESS + 1 DONE.
  - freeze is high for WAIT_CYCLES+1 of them.
  - Upstream registers advance at the end of DONE.
  - mem_rdata is valid from DONE and stays held until the next completed read.
- No request: stay IDLE, freeze=0, strobes high, mem_rdata held.
- Back-to-back accesses: the following instruction is seen in IDLE in the cycle after DONE. There are no idle cycles beyond the mandatory IDLE cycle.
- Reset mid-access: abort immediately with strobes high. No partial write is guaranteed; the SRAM content at that address is undefined.
- Only one outstanding access at a time; there is no buffering.

Test Plan:
- Reset: hold rst=0 with mem_r_en=1 -> freeze=0, sram_we_n=1, sram_oe_n=1, mem_rdata=0.
- Store: alu_res=1024+8, val_Rm=0xDEADBEEF, mem_w_en=1, WAIT_CYCLES=4.
  - sram_addr=2 and sram_wdata=0xDEADBEEF.
  - sram_we_n=0 for exactly 4 cycles.
  - freeze=1 for 5 cycles, then ready=1 for 1 cycle.
- Load: SRAM word 2 returns 0xDEADBEEF, alu_res=1032, mem_r_en=1.
  - sram_oe_n=0 for 4 cycles.
  - mem_rdata=0xDEADBEEF in the DONE cycle and held afterwards.
- Simultaneous enables: mem_r_en=mem_w_en=1, val_Rm=0x1234 -> write performed with sram_oe_n staying 1, mem_rdata unchanged.
- Back-to-back: store to 1024, then load from 1028 on consecutive instructions -> two complete 6-cycle sequences with no overlap of sram_we_n and sram_oe_n.
- Reset mid-access: assert rst=0 at ACCESS cnt=2 -> strobes go 1 asynchronously, state IDLE; after release a new load completes normally.
